i2s_serdes: RTL and testbench

Bit-level I2S master for the ADAU1761 codec on the audio path. It generates `bclk` and `lrclk` from the system clock. It serializes stereo DAC frames taken from an AXI-stream sink onto `sdata_o`, and deserializes `sdata_i` into stereo ADC frames on an AXI-stream source. It sits between the codec pins and the `dsp` block.

---
 rtl/i2s_serdes.sv | 190 +++++++++++++++++++
 tb/tb_i2s_serdes.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serdes.sv
// i2s_serdes: bit-level I2S master for the ADAU1761 codec.
//
// Generates bclk/lrclk from clk, serializes stereo DAC frames from a
// stream sink onto sdata_o, and deserializes sdata_i into stereo ADC frames
// on a stream source. Frame packing on both streams is {left, right}, with left in the MSBs.
//
// Ports:
//   clk, reset (async, active-low)
//   sdata_i        ADC serial data from the codec
//   sdata_o        DAC serial data to the codec
//   bclk, lrclk    bit clock / frame clock (lrclk 0 = left, 1 = right)
//   codec_addr     constant CODEC_ADDR
//   dac_sample_*   stream sink   (data, valid, ready)
//   adc_sample_*   stream source (data, valid, ready)
//
// Handshake: a beat transfers on any clk edge where valid && ready are both
// high. A source holds valid and data steady until the transfer. dac_sample_ready and
// adc_sample_valid come straight from flops and do not depend on the other side.
//
// Optional feature: define I2S_SERDES_LOOPBACK_EN so that the RX shifter samples the
// internal sdata_o register instead of sdata_i.
module i2s_serdes #(
  parameter int         CLK_DIV    = 16,
  parameter int         SAMPLE_W   = 24,
  parameter int         SLOT_W     = 32,
  parameter logic [1:0] CODEC_ADDR = 2'b00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sdata_i,
  output logic                  sdata_o,
  output logic                  bclk,
  output logic                  lrclk,
  output logic [1:0]            codec_addr,
  input  logic [2*SAMPLE_W-1:0] dac_sample_data,
  input  logic                  dac_sample_valid,
  output logic                  dac_sample_ready,
  output logic [2*SAMPLE_W-1:0] adc_sample_data,
  output logic                  adc_sample_valid,
  input  logic                  adc_sample_ready
);

  localparam int FW = 2 * SAMPLE_W;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_W);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);
  localparam logic [BW-1:0] L_LAST   = BW'(SAMPLE_W);
  localparam logic [BW-1:0] R_FIRST  = BW'(SLOT_W + 1);
  localparam logic [BW-1:0] R_LAST   = BW'(SLOT_W + SAMPLE_W);

  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_o_q, sdata_o_d;
  logic [FW-1:0]       hold_data_q, hold_data_d;
  logic                hold_full_q, hold_full_d;
  logic [FW-1:0]       tx_frame_q, tx_frame_d;
  logic [FW-1:0]       tx_shift_q, tx_shift_d;
  logic [SAMPLE_W-1:0] rx_left_q, rx_left_d;
  logic [SAMPLE_W-1:0] rx_right_q, rx_right_d;
  logic [FW-1:0]       adc_data_q, adc_data_d;
  logic                adc_valid_q, adc_valid_d;

  logic          tick, rise, fall, wrap;
  logic [BW-1:0] bit_next;
  logic          rx_din;

`ifdef I2S_SERDES_LOOPBACK_EN
  assign rx_din = sdata_o_q;
`else
  assign rx_din = sdata_i;
`endif

  always_comb begin
    div_cnt_d   = div_cnt_q;
    bclk_d      = bclk_q;
    bit_cnt_d   = bit_cnt_q;
    lrclk_d     = lrclk_q;
    sdata_o_d   = sdata_o_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    tx_frame_d  = tx_frame_q;
    tx_shift_d  = tx_shift_q;
    rx_left_d   = rx_left_q;
    rx_right_d  = rx_right_q;
    adc_data_d  = adc_data_q;
    adc_valid_d = adc_valid_q;

    tick = (div_cnt_q == DIV_LAST);
    rise = tick && !bclk_q;
    fall = tick && bclk_q;
    wrap = fall && (bit_cnt_q == BIT_LAST);
    bit_next = wrap ? '0 : bit_cnt_q + 1'b1;

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    if (tick) begin
      bclk_d = !bclk_q;
    end

    // lrclk and sdata_o follow the bit index being entered, so lrclk flips one
    // bclk ahead of the channel MSB (the I2S one-bit delay).
    if (fall) begin
      bit_cnt_d = bit_next;
      lrclk_d   = (bit_next >= SLOT_B);
      if (wrap) begin
        // An empty holding register at the wrap replays the previous frame.
        tx_frame_d = hold_full_q ? hold_data_q : tx_frame_q;
        tx_shift_d = hold_full_q ? hold_data_q : tx_frame_q;
        sdata_o_d  = 1'b0;
      end else if (((bit_next != '0) && (bit_next <= L_LAST)) ||
                   ((bit_next >= R_FIRST) && (bit_next <= R_LAST))) begin
        sdata_o_d  = tx_shift_q[FW-1];
        tx_shift_d = {tx_shift_q[FW-2:0], 1'b0};
      end else begin
        sdata_o_d = 1'b0;
      end
    end

    // A handshake is possible only while the holding register is empty. That
    // empty register also makes a coincident wrap replay the old frame, while
    // the new data is kept for the next wrap.
    if (dac_sample_valid && !hold_full_q) begin
      hold_data_d = dac_sample_data;
      hold_full_d = 1'b1;
    end else if (wrap) begin
      hold_full_d = 1'b0;
    end

    if (rise) begin
      if ((bit_cnt_q != '0) && (bit_cnt_q <= L_LAST)) begin
        rx_left_d = {rx_left_q[SAMPLE_W-2:0], rx_din};
      end else if ((bit_cnt_q >= R_FIRST) && (bit_cnt_q <= R_LAST)) begin
        rx_right_d = {rx_right_q[SAMPLE_W-2:0], rx_din};
      end
    end

    // A new frame always wins over an unread one or a coincident handshake.
    if (wrap) begin
      adc_data_d  = {rx_left_q, rx_right_q};
      adc_valid_d = 1'b1;
    end else if (adc_valid_q && adc_sample_ready) begin
      adc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= '0;
      lrclk_q     <= 1'b0;
      sdata_o_q   <= 1'b0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      tx_frame_q  <= '0;
      tx_shift_q  <= '0;
      rx_left_q   <= '0;
      rx_right_q  <= '0;
      adc_data_q  <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_o_q   <= sdata_o_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      tx_frame_q  <= tx_frame_d;
      tx_shift_q  <= tx_shift_d;
      rx_left_q   <= rx_left_d;
      rx_right_q  <= rx_right_d;
      adc_data_q  <= adc_data_d;
      adc_valid_q <= adc_valid_d;
    end
  end

  assign bclk             = bclk_q;
  assign lrclk            = lrclk_q;
  assign sdata_o          = sdata_o_q;
  assign codec_addr       = CODEC_ADDR;
  assign dac_sample_ready = !hold_full_q;
  assign adc_sample_data  = adc_data_q;
  assign adc_sample_valid = adc_valid_q;

endmodule

// File: tb/tb_i2s_serdes.sv
// Testbench for i2s_serdes with default parameters (CLK_DIV=16, SAMPLE_W=24,
// SLOT_W=32). Timing is modelled from a cycle counter that restarts at reset:
// bclk toggles every 16 cycles, the bit index advances every 32, and a frame
// wraps every 2048. DAC frames and expected ADC frames are tracked in queues.
module tb_i2s_serdes;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sdata_i = 1'b0;
  logic        sdata_o, bclk, lrclk;
  logic [1:0]  codec_addr;
  logic [47:0] dac_data = '0;
  logic        dac_valid = 1'b0;
  logic        dac_ready;
  logic [47:0] adc_data;
  logic        adc_valid;
  logic        adc_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rdy_s = 1'b0;

  // model state
  logic [47:0] exp_q[$];
  logic [47:0] tx_q[$];
  int          tx_cyc_q[$];
  logic [47:0] tx_cur = '0;
  logic [47:0] rx_next = '0;
  logic [47:0] rx_cur = '0;
  logic [47:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  int          rx_idx = -1;

  i2s_serdes dut (
    .clk              (clk),
    .reset            (reset),
    .sdata_i          (sdata_i),
    .sdata_o          (sdata_o),
    .bclk             (bclk),
    .lrclk            (lrclk),
    .codec_addr       (codec_addr),
    .dac_sample_data  (dac_data),
    .dac_sample_valid (dac_valid),
    .dac_sample_ready (dac_ready),
    .adc_sample_data  (adc_data),
    .adc_sample_valid (adc_valid),
    .adc_sample_ready (adc_ready)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) rdy_s <= adc_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      if (errors <= 30)
        $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // I2S slot map: left MSB at bit 1, right MSB at bit 33, zeros elsewhere.
  function automatic logic slot_bit(input logic [47:0] f, input int b);
    if (b >= 1 && b <= 24)  return f[48-b];
    if (b >= 33 && b <= 56) return f[56-b];
    return 1'b0;
  endfunction

  // scoreboard / model, evaluated on the falling clk edge
  always @(negedge clk) begin
    int c;
    int bit_n;
    logic hold_full;
    if (!reset) begin
      exp_q.delete();
      tx_q.delete();
      tx_cyc_q.delete();
      tx_cur    = '0;
      rx_cur    = '0;
      exp_data  = '0;
      exp_valid = 1'b0;
      rx_idx    = -1;
      sdata_i   = 1'b0;
    end else begin
      c     = cyc;
      bit_n = (c / 32) % 64;
      if (c % 2048 == 0 && c > 0) begin
        // frames handed over strictly before the wrap are used at the wrap
        if (tx_q.size() > 0 && tx_cyc_q[0] < c) begin
          tx_cur = tx_q.pop_front();
          void'(tx_cyc_q.pop_front());
        end
      end
      if (exp_valid && rdy_s) exp_valid = 1'b0;
      if (c % 2048 == 0 && c > 0 && exp_q.size() > 0) begin
        exp_valid = 1'b1;
        exp_data  = exp_q.pop_front();
      end
      if (c / 2048 != rx_idx) begin
        rx_idx = c / 2048;
        rx_cur = rx_next;
`ifdef I2S_SERDES_LOOPBACK_EN
        exp_q.push_back(tx_cur);
`else
        exp_q.push_back(rx_cur);
`endif
      end
      sdata_i   = slot_bit(rx_cur, bit_n);
      hold_full = (tx_q.size() > 0) && (tx_cyc_q[0] <= c);

      chk("bclk", bclk, ((c / 16) % 2 == 1));
      chk("lrclk", lrclk, (bit_n >= 32));
      chk("sdata_o", sdata_o, slot_bit(tx_cur, bit_n));
      chk("dac_ready", dac_ready, !hold_full);
      chk("adc_valid", adc_valid, exp_valid);
      chk("adc_data", adc_data, exp_data);
    end
  end

  // driver tasks
  task automatic send(input logic [47:0] d);
    int n;
    @(negedge clk);
    dac_data  = d;
    dac_valid = 1'b1;
    n = 0;
    while (!dac_ready && n < 4096) begin
      @(negedge clk);
      n++;
    end
    if (!dac_ready) begin
      chk("dac_hs_timeout", dac_ready, 1'b1);
    end else begin
      tx_q.push_back(d);
      tx_cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    dac_valid = 1'b0;
  endtask

  // present a frame so that the handshake lands on clk edge number target
  task automatic send_at(input logic [47:0] d, input int target);
    while (cyc < target - 2) @(negedge clk);
    send(d);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_bclk"}, bclk, 1'b0);
    chk({tag, "_lrclk"}, lrclk, 1'b0);
    chk({tag, "_sdata_o"}, sdata_o, 1'b0);
    chk({tag, "_adc_valid"}, adc_valid, 1'b0);
    chk({tag, "_adc_data"}, adc_data, 48'h0);
    chk({tag, "_dac_ready"}, dac_ready, 1'b1);
  endtask

  function automatic logic [47:0] rand_frame();
    logic [23:0] l;
    logic [23:0] r;
    l = 24'($urandom_range(0, 32'h00FF_FFFF));
    r = 24'($urandom_range(0, 32'h00FF_FFFF));
    return {l, r};
  endfunction

  initial begin
    logic [47:0] r1, r2, r3;
    r1 = rand_frame();
    r2 = rand_frame();
    r3 = rand_frame();

    // reset held for 5 cycles
    reset     = 1'b0;
    adc_ready = 1'b1;
    rx_next   = 48'h123456_FEDCBA;
    repeat (5) @(negedge clk);
    check_reset("rst");
    reset = 1'b1;
    chk("codec_addr", codec_addr, 2'b00);

    // DAC frame accepted before the first wrap, ADC frame 0 = 123456/FEDCBA
    send(48'hA5A5A5_3C3C3C);
    wait_until(1000);
    rx_next = r1;
    wait_until(2060);
`ifdef I2S_SERDES_LOOPBACK_EN
    chk("adc_frame0", adc_data, 48'h0);
`else
    chk("adc_frame0", adc_data, 48'h123456_FEDCBA);
`endif

    // no further DAC frames (replay); ADC backpressure across two wraps
    wait_until(2100);
    adc_ready = 1'b0;
    wait_until(3000);
    rx_next = r2;
    wait_until(5000);
    rx_next = r3;
    wait_until(6200);
    chk("adc_overflow_valid", adc_valid, 1'b1);
`ifndef I2S_SERDES_LOOPBACK_EN
    chk("adc_overflow_data", adc_data, r2);
`endif
    wait_until(6500);
    adc_ready = 1'b1;

    // handshake on the wrap edge: old frame sent, new one in the next frame
    send_at(48'hC0FFEE_123ABC, 8192);
    chk("coincident_ready", dac_ready, 1'b0);
    wait_until(9000);
    chk("coincident_hold", dac_ready, 1'b0);
    send(48'h5A5A5A_0F0F0F);
    wait_until(11000);
    rx_next = rand_frame();
`ifdef I2S_SERDES_LOOPBACK_EN
    send(48'h800001_7FFFFF);
`else
    send(rand_frame());
`endif
    wait_until(16500);
`ifdef I2S_SERDES_LOOPBACK_EN
    chk("loopback", adc_data, 48'h800001_7FFFFF);
`endif

    // reset in the middle of a frame
    wait_until(17000);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("midrst");
    reset   = 1'b1;
    rx_next = rand_frame();
    send(rand_frame());
    wait_until(4300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
